fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage front end: owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Delivers instr/pcplus with a valid flag to the IF/ID pipeline register, which loads on valid & ~stall.
- Handles hazard-unit stalls, branch/jump redirects from ID (including redirects during an outstanding fetch), and misaligned-target detection.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset (pcplus after reset = 32'h0000_3004)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low (asserted when 0)
stall  in  1  downstream IF/ID cannot accept this cycle
redirect  in  1  taken branch/jump from ID this cycle
redirect_pc  in  32  target PC for redirect
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch word address
imem_ready  in  1  imem_rdata valid; completes request this cycle
imem_rdata  in  32  fetched instruction
instr  out  32  instruction to IF/ID
pcplus  out  32  PC+4 of delivered instruction
valid  out  1  instr/pcplus meaningful this cycle
misalign  out  1  sticky: redirect target had nonzero [1:0]

Behaviour:
- Reset (rst==0 at edge): pc=RESET_PC, state=FETCH, hold regs=0, kill_pc=0, misalign=0. While rst==0: imem_req=0, valid=0, instr=0, pcplus=32'h3004, imem_addr=RESET_PC. Reset mid-request abandons the request; any late imem_ready is ignored.
- States: FETCH, HOLD, KILL, HALT.
- Handshake rule: while imem_req=1 and imem_ready=0, imem_addr must not change. Request completes on the first cycle with imem_req & imem_ready. Memory latency may be 0 (same-cycle ready) or N cycles.
- FETCH:
  - imem_req=1, imem_addr=pc, pcplus=pc+4.
  - valid=imem_ready, instr=imem_rdata (combinational pass-through).
  - Transitions by priority:
    1. redirect & ready: discard data. Aligned target: pc<=redirect_pc, stay FETCH. Misaligned target: misalign<=1, go HALT.
    2. redirect & ~ready: kill_pc<=redirect_pc, go KILL. Misalignment is checked when the request completes.
    3. ready & ~stall: handoff, pc<=pc+4, stay FETCH. Back-to-back fetches give one instruction per cycle at zero latency.
    4. ready & stall: hold_instr<=imem_rdata, go HOLD. pc unchanged.
    5. ~ready: stay.
- HOLD:
  - imem_req=0, valid=1, instr=hold_instr, pcplus=pc+4.
  - redirect: drop held instr, then same aligned/misaligned handling as FETCH rule 1 (pc<=target, FETCH; or HALT).
  - else ~stall: handoff, pc<=pc+4, go FETCH.
  - else stay.
- KILL:
  - imem_req=1, imem_addr=pc (old address), valid=0.
  - New redirect overwrites kill_pc (last one wins).
  - On ready: data discarded. Aligned: pc<=kill_pc (or redirect_pc if redirect is asserted that same cycle), go FETCH. Misaligned: misalign<=1, go HALT.
- HALT: imem_req=0, valid=0, misalign=1. Exit only by reset.
- Priorities: redirect beats stall in every state. stall never blocks a redirect.
- Arithmetic: pc+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Alignment: pc[1:0] is always 0 outside HALT.

Decomposition:
- Shared package: RESET_PC constant, state enum (FETCH/HOLD/KILL/HALT), word size / PC increment constant.
- No sub-module. The pc register, hold buffer and FSM sit in one module of about 150–200 lines.

Test Plan:
- Reset then imem_ready=1 every cycle, stall=0: imem_addr sequence 0x3000, 0x3004, 0x3008; valid=1 each cycle; pcplus 0x3004, 0x3008, 0x300C.
- imem latency 3 cycles: imem_req=1 with imem_addr=0x3000 stable for 3 cycles; valid=0 until ready; then pcplus=0x3004, next imem_addr=0x3004.
- Data returns (0x8C010000) with stall=1 for 2 cycles: HOLD; valid=1, instr=0x8C010000, imem_req=0 for 2 cycles; on stall release next imem_addr=0x3004.
- Redirect to 0x3040 during outstanding fetch of 0x3008 (latency 2): imem_addr stays 0x3008 until ready; valid=0 on that return; next imem_addr=0x3040. A second redirect to 0x3080 in KILL makes the next address 0x3080.
- Redirect to 0x3042: misalign=1, imem_req=0 and valid=0 held for 10 cycles; rst=0 for one cycle restores imem_addr=0x3000 and misalign=0.
- Redirect and stall in the same cycle while in HOLD: hold is dropped and next imem_addr=redirect_pc. rst=0 during an outstanding request: a subsequent imem_ready is ignored and the fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the IF-stage fetch unit.
package fetch_unit_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    KILL,
    HALT
  } fetch_state_t;

  function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// IF-stage front end: owns the PC, issues word fetches over req/ready and
// delivers instr/pcplus to IF/ID, honouring stalls and ID redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pcplus,
  output logic              valid,
  output logic              misalign
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] hold_instr;
  logic [WORD_W-1:0] kill_pc;
  logic              misalign_q;
  logic [WORD_W-1:0] pc_seq;
  logic [WORD_W-1:0] kill_target;

  assign pc_seq      = pc + PC_INC;
  assign kill_target = redirect ? redirect_pc : kill_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_instr <= '0;
      kill_pc    <= '0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              if (is_aligned(redirect_pc)) begin
                pc <= redirect_pc;
              end else begin
                misalign_q <= 1'b1;
                state      <= HALT;
              end
            end else if (!stall) begin
              pc <= pc_seq;
            end else begin
              hold_instr <= imem_rdata;
              state      <= HOLD;
            end
          end else if (redirect) begin
            // request still in flight: its address must stay put, so park the target
            kill_pc <= redirect_pc;
            state   <= KILL;
          end
        end
        HOLD: begin
          if (redirect) begin
            if (is_aligned(redirect_pc)) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end else begin
              misalign_q <= 1'b1;
              state      <= HALT;
            end
          end else if (!stall) begin
            pc    <= pc_seq;
            state <= FETCH;
          end
        end
        KILL: begin
          if (imem_ready) begin
            if (is_aligned(kill_target)) begin
              pc    <= kill_target;
              state <= FETCH;
            end else begin
              misalign_q <= 1'b1;
              state      <= HALT;
            end
          end else if (redirect) begin
            kill_pc <= redirect_pc;
          end
        end
        HALT: begin
        end
        default: state <= HALT;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    instr     = '0;
    pcplus    = pc_seq;
    valid     = 1'b0;
    if (!rst) begin
      imem_addr = RESET_PC;
      pcplus    = RESET_PC + PC_INC;
    end else begin
      unique case (state)
        FETCH: begin
          imem_req = 1'b1;
          valid    = imem_ready;
          instr    = imem_rdata;
        end
        HOLD: begin
          valid = 1'b1;
          instr = hold_instr;
        end
        KILL:    imem_req = 1'b1;
        HALT:    imem_req = 1'b0;
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid, misalign;
  logic [31:0] imem_addr, instr, pcplus;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .pcplus(pcplus), .valid(valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, redirect;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr, epcplus;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  // Drive one cycle of inputs away from the rising edge, then let outputs settle.
  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] rp, input logic rdy,
                               input logic [31:0] rdat);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    imem_ready = rdy; imem_rdata = rdat;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ereq, input logic [31:0] eaddr,
                          input logic evalid, input logic [31:0] einstr,
                          input logic [31:0] epcplus, input logic emis);
    checkOutput({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, ereq});
    checkOutput({tag, ".valid"}, {31'b0, valid}, {31'b0, evalid});
    if (rst) checkOutput({tag, ".misalign"}, {31'b0, misalign}, {31'b0, emis});
    if (ereq || !rst) checkOutput({tag, ".imem_addr"}, imem_addr, eaddr);
    if (evalid || !rst) begin
      checkOutput({tag, ".instr"}, instr, einstr);
      checkOutput({tag, ".pcplus"}, pcplus, epcplus);
    end
  endtask

  function automatic void addVec(logic r, logic s, logic rd, logic [31:0] rp,
                                 logic rdy, logic [31:0] rdat, logic ereq,
                                 logic [31:0] eaddr, logic evalid,
                                 logic [31:0] einstr, logic [31:0] epc, logic emis);
    vecs.push_back('{r, s, rd, rp, rdy, rdat, ereq, eaddr, evalid, einstr, epc, emis});
  endfunction

  // Transaction-level reference: where fetching is, what is waiting to be
  // delivered, whether the in-flight word is doomed, and whether we gave up.
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  bit          m_doomed;
  logic [31:0] m_target;
  bit          m_halted;
  logic        p_req, p_valid;
  logic [31:0] p_addr, p_instr, p_pcplus;

  function automatic void modelGoto(logic [31:0] t);
    m_held.delete();
    m_doomed = 0;
    if (t % 4 != 0) m_halted = 1;
    else m_pc = t;
  endfunction

  function automatic void modelPredict();
    p_req = 0; p_valid = 0; p_addr = m_pc; p_instr = 0; p_pcplus = m_pc + 4;
    if (!rst) begin
      p_addr = RST_PC; p_pcplus = RST_PC + 4;
    end else if (m_halted) begin
    end else if (m_held.size() > 0) begin
      p_valid = 1; p_instr = m_held[0];
    end else if (m_doomed) begin
      p_req = 1;
    end else begin
      p_req = 1; p_valid = imem_ready; p_instr = imem_rdata;
    end
  endfunction

  function automatic void modelStep();
    if (!rst) begin
      m_pc = RST_PC; m_held.delete(); m_doomed = 0; m_halted = 0;
    end else if (m_halted) begin
    end else if (m_held.size() > 0) begin
      if (redirect) modelGoto(redirect_pc);
      else if (!stall) begin m_held.delete(); m_pc = m_pc + 4; end
    end else if (m_doomed) begin
      if (redirect) m_target = redirect_pc;
      if (imem_ready) modelGoto(m_target);
    end else if (redirect) begin
      if (imem_ready) modelGoto(redirect_pc);
      else begin m_doomed = 1; m_target = redirect_pc; end
    end else if (imem_ready) begin
      if (stall) m_held.push_back(imem_rdata);
      else m_pc = m_pc + 4;
    end
  endfunction

  initial begin
    int halt_cnt;
    rst = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0;

    //     rst st rd rpc           rdy rdata         req addr          vld instr         pcplus        mis
    addVec(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 32'h0,        32'h0000_3004, 0);
    addVec(1, 0, 0, 32'h0,        1, 32'h1111_1111, 1, 32'h0000_3000, 1, 32'h1111_1111, 32'h0000_3004, 0);
    addVec(1, 0, 0, 32'h0,        1, 32'h2222_2222, 1, 32'h0000_3004, 1, 32'h2222_2222, 32'h0000_3008, 0);
    addVec(1, 0, 0, 32'h0,        1, 32'h3333_3333, 1, 32'h0000_3008, 1, 32'h3333_3333, 32'h0000_300C, 0);
    addVec(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 32'h0,        32'h0,        0);
    addVec(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 32'h0,        32'h0,        0);
    addVec(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 32'h0,        32'h0,        0);
    addVec(1, 1, 0, 32'h0,        1, 32'h8C01_0000, 1, 32'h0000_300C, 1, 32'h8C01_0000, 32'h0000_3010, 0);
    addVec(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8C01_0000, 32'h0000_3010, 0);
    addVec(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8C01_0000, 32'h0000_3010, 0);
    addVec(1, 0, 1, 32'h0000_3040, 0, 32'h0,        1, 32'h0000_3010, 0, 32'h0,        32'h0,        0);
    addVec(1, 0, 1, 32'h0000_3080, 0, 32'h0,        1, 32'h0000_3010, 0, 32'h0,        32'h0,        0);
    addVec(1, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h0000_3010, 0, 32'h0,        32'h0,        0);
    addVec(1, 0, 0, 32'h0,        1, 32'h4444_4444, 1, 32'h0000_3080, 1, 32'h4444_4444, 32'h0000_3084, 0);
    addVec(1, 1, 0, 32'h0,        1, 32'h5555_5555, 1, 32'h0000_3084, 1, 32'h5555_5555, 32'h0000_3088, 0);
    addVec(1, 1, 1, 32'h0000_30C0, 0, 32'h0,        0, 32'h0,        1, 32'h5555_5555, 32'h0000_3088, 0);
    addVec(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_30C0, 0, 32'h0,        32'h0,        0);
    addVec(1, 0, 1, 32'h0000_3042, 1, 32'h6666_6666, 1, 32'h0000_30C0, 1, 32'h6666_6666, 32'h0000_30C4, 0);
    addVec(1, 0, 1, 32'h0000_3000, 1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1);
    addVec(1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1);
    addVec(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 32'h0,        32'h0000_3004, 0);
    addVec(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3000, 0, 32'h0,        32'h0,        0);
    addVec(0, 0, 0, 32'h0,        1, 32'h9999_9999, 0, 32'h0000_3000, 0, 32'h0,        32'h0000_3004, 0);
    addVec(1, 0, 0, 32'h0,        1, 32'h7777_7777, 1, 32'h0000_3000, 1, 32'h7777_7777, 32'h0000_3004, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc,
                    vecs[i].ready, vecs[i].rdata);
      checkAll($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid,
               vecs[i].einstr, vecs[i].epcplus, vecs[i].emis);
    end

    // Misaligned target discovered when a killed request finally completes.
    applyStimulus(1, 0, 1, 32'h0000_3103, 0, 32'h0);
    checkAll("kill_mis_a", 1, 32'h0000_3004, 0, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hABCD_0000);
    checkAll("kill_mis_b", 1, 32'h0000_3004, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    32'h0000_4000, 1'($urandom_range(1)), $urandom);
      checkAll($sformatf("halt%0d", i), 0, 32'h0, 0, 32'h0, 32'h0, 1);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
    checkAll("halt_rst", 0, 32'h0000_3000, 0, 32'h0, 32'h0000_3004, 0);

    // PC increment wraps modulo 2^32.
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678);
    checkAll("wrap_a", 1, 32'h0000_3000, 1, 32'h1234_5678, 32'h0000_3004, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hAAAA_0001);
    checkAll("wrap_b", 1, 32'hFFFF_FFFC, 1, 32'hAAAA_0001, 32'h0000_0000, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
    checkAll("wrap_c", 1, 32'h0000_0000, 0, 32'h0, 32'h0, 0);

    // Randomized traffic against the reference model.
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, rd, rdy;
      logic [31:0] rp;
      r = (i == 0 || $urandom_range(99) == 0 || halt_cnt > 6) ? 1'b0 : 1'b1;
      s = ($urandom_range(3) == 0);
      rd = ($urandom_range(7) == 0);
      rp = {20'h0, 12'($urandom_range(4095))} & 32'hFFFF_FFFC;
      if ($urandom_range(15) == 0) rp[1:0] = 2'($urandom_range(3, 1));
      rdy = ($urandom_range(2) != 0);
      applyStimulus(r, s, rd, rp, rdy, $urandom);
      modelPredict();
      checkAll($sformatf("rand%0d", i), p_req, p_addr, p_valid, p_instr, p_pcplus,
               m_halted);
      modelStep();
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
